// File: rtl/iq_loop_ctrl.sv
// rtl/iq_loop_ctrl.sv - per-channel DC-offset and VGA attenuation feedback controller
module iq_loop_ctrl #(
    parameter int NUM_CH        = 2,
    parameter int ADC_W         = 8,
    parameter int DAC_W         = 6,
    parameter int ATTEN_W       = 10,
    parameter int ATTEN_INIT    = 512,
    parameter int ACC_LOG2      = 5,
    parameter int SETTLE_CYCLES = 8,
    parameter int DC_TOL        = 1,
    parameter int LOCK_COUNT    = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        adc_valid,
    input  logic [NUM_CH*ADC_W-1:0]     adc_data,
    input  logic [ADC_W-1:0]            agc_target,
    input  logic [ADC_W-1:0]            agc_hyst,
    output logic [NUM_CH*DAC_W-1:0]     current_dac_0,
    output logic [NUM_CH*DAC_W-1:0]     current_dac_1,
    output logic [NUM_CH*ATTEN_W-1:0]   vga_atten,
    output logic                        update_pulse,
    output logic                        busy,
    output logic                        locked
);

    localparam int SUM_W = ADC_W + ACC_LOG2 + 1;
    localparam int OC_W  = DAC_W + 1;
    localparam int CNT_W = ACC_LOG2;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int LCK_W = $clog2(LOCK_COUNT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_ACCUM  = 2'd2;
    localparam logic [1:0] S_UPDATE = 2'd3;

    localparam logic [CNT_W-1:0]        LAST_SAMPLE = CNT_W'(2**ACC_LOG2 - 1);
    localparam logic [SET_W-1:0]        LAST_SETTLE = SET_W'(SETTLE_CYCLES - 1);
    localparam logic signed [SUM_W-1:0] TOL_P       = SUM_W'(DC_TOL);
    localparam logic signed [SUM_W-1:0] TOL_N       = -TOL_P;
    localparam logic signed [OC_W-1:0]  OC_MAX      = OC_W'(2**DAC_W - 1);
    localparam logic signed [OC_W-1:0]  OC_MIN      = -OC_MAX;
    localparam logic [ATTEN_W-1:0]      ATT_MAX     = '1;
    localparam logic [ATTEN_W-1:0]      ATT_RST     = ATTEN_W'(ATTEN_INIT);
    localparam logic [LCK_W-1:0]        LOCK_FULL   = LCK_W'(LOCK_COUNT);
    localparam logic [ADC_W:0]          MID         = (ADC_W+1)'(2**(ADC_W-1));

    logic [1:0]               state_q, state_d;
    logic [SET_W-1:0]         settle_q, settle_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [LCK_W-1:0]         lock_q, lock_d;
    logic signed [SUM_W-1:0]  sum_q [NUM_CH];
    logic signed [SUM_W-1:0]  sum_d [NUM_CH];
    logic [ADC_W:0]           peak_q [NUM_CH];
    logic [ADC_W:0]           peak_d [NUM_CH];
    logic signed [OC_W-1:0]   oc_q [NUM_CH];
    logic signed [OC_W-1:0]   oc_d [NUM_CH];
    logic [ATTEN_W-1:0]       atten_q [NUM_CH];
    logic [ATTEN_W-1:0]       atten_d [NUM_CH];
    logic [NUM_CH*DAC_W-1:0]  dac0_q, dac0_d, dac1_q, dac1_d;
    logic                     pulse_q, pulse_d;
    logic                     busy_q, locked_q;

    // AGC thresholds, widened by one bit so target+hyst cannot wrap; low side clamps at 0
    logic [ADC_W:0] agc_hi, agc_lo;
    assign agc_hi = {1'b0, agc_target} + {1'b0, agc_hyst};
    assign agc_lo = (agc_target >= agc_hyst) ? {1'b0, agc_target - agc_hyst} : '0;

    // Next-state: sequencing, window accumulation and the per-window loop updates
    always_comb begin
        logic signed [ADC_W:0]   s;
        logic [ADC_W:0]          mag;
        logic signed [SUM_W-1:0] mean;
        logic                    changed;
        s        = '0;
        mag      = '0;
        mean     = '0;
        changed  = 1'b0;
        state_d  = state_q;
        settle_d = settle_q;
        cnt_d    = cnt_q;
        lock_d   = lock_q;
        pulse_d  = 1'b0;
        dac0_d   = '0;
        dac1_d   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sum_d[k]   = sum_q[k];
            peak_d[k]  = peak_q[k];
            oc_d[k]    = oc_q[k];
            atten_d[k] = atten_q[k];
        end

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d  = S_SETTLE;
                    settle_d = '0;
                end
            end
            S_SETTLE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (settle_q == LAST_SETTLE) begin
                    state_d = S_ACCUM;
                    cnt_d   = '0;
                    for (int k = 0; k < NUM_CH; k++) begin
                        sum_d[k]  = '0;
                        peak_d[k] = '0;
                    end
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            S_ACCUM: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (adc_valid) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        s   = $signed({1'b0, adc_data[k*ADC_W +: ADC_W]} - MID);
                        mag = s[ADC_W] ? $unsigned(-s) : $unsigned(s);
                        sum_d[k] = sum_q[k] + {{(SUM_W-ADC_W-1){s[ADC_W]}}, s};
                        if (mag > peak_q[k]) peak_d[k] = mag;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_SAMPLE) begin
                        state_d = S_UPDATE;
                        pulse_d = 1'b1;
                    end
                end
            end
            default: begin
                for (int k = 0; k < NUM_CH; k++) begin
                    mean = sum_q[k] >>> ACC_LOG2;
                    if (mean > TOL_P && oc_q[k] != OC_MAX) begin
                        oc_d[k] = oc_q[k] + OC_W'(1);
                        changed = 1'b1;
                    end else if (mean < TOL_N && oc_q[k] != OC_MIN) begin
                        oc_d[k] = oc_q[k] - OC_W'(1);
                        changed = 1'b1;
                    end
                    if (peak_q[k] > agc_hi && atten_q[k] != ATT_MAX) begin
                        atten_d[k] = atten_q[k] + ATTEN_W'(1);
                        changed    = 1'b1;
                    end else if (peak_q[k] < agc_lo && atten_q[k] != '0) begin
                        atten_d[k] = atten_q[k] - ATTEN_W'(1);
                        changed    = 1'b1;
                    end
                end
                if (changed)                lock_d = '0;
                else if (lock_q != LOCK_FULL) lock_d = lock_q + LCK_W'(1);
                state_d  = enable ? S_SETTLE : S_IDLE;
                settle_d = '0;
            end
        endcase

        if (!enable) lock_d = '0;

        // Signed offset code split onto the two unipolar current DACs
        for (int k = 0; k < NUM_CH; k++) begin
            if (!oc_d[k][OC_W-1] && oc_d[k] != '0) dac0_d[k*DAC_W +: DAC_W] = DAC_W'(oc_d[k]);
            if (oc_d[k][OC_W-1])                   dac1_d[k*DAC_W +: DAC_W] = DAC_W'(-oc_d[k]);
        end
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            settle_q <= '0;
            cnt_q    <= '0;
            lock_q   <= '0;
            dac0_q   <= '0;
            dac1_q   <= '0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                sum_q[k]   <= '0;
                peak_q[k]  <= '0;
                oc_q[k]    <= '0;
                atten_q[k] <= ATT_RST;
            end
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            lock_q   <= lock_d;
            dac0_q   <= dac0_d;
            dac1_q   <= dac1_d;
            pulse_q  <= pulse_d;
            busy_q   <= (state_d != S_IDLE);
            locked_q <= (lock_d == LOCK_FULL);
            for (int k = 0; k < NUM_CH; k++) begin
                sum_q[k]   <= sum_d[k];
                peak_q[k]  <= peak_d[k];
                oc_q[k]    <= oc_d[k];
                atten_q[k] <= atten_d[k];
            end
        end
    end

    // Pack per-channel attenuation registers onto the output bus
    always_comb begin
        vga_atten = '0;
        for (int k = 0; k < NUM_CH; k++) vga_atten[k*ATTEN_W +: ATTEN_W] = atten_q[k];
    end

    assign current_dac_0 = dac0_q;
    assign current_dac_1 = dac1_q;
    assign update_pulse  = pulse_q;
    assign busy          = busy_q;
    assign locked        = locked_q;

endmodule

// File: doc/iq_loop_ctrl.md
# iq_loop_ctrl

Synthesizable per-channel DC-offset and VGA-attenuation feedback controller for the receive analog front end. It replaces the fixed-code stimulus previously driven into the I/Q chain models. It closes the loops from ADC samples back to the current-DAC pair and the VGA attenuation code. It generalises to NUM_CH channels with parametric ADC, DAC and attenuation widths, plus a windowed estimator, settling delay and lock detection.

## Interface
- NUM_CH, 2, number of independent channels (2 = I/Q)
- ADC_W, 8, ADC sample width, offset-binary (midscale 2^(ADC_W-1))
- DAC_W, 6, width of each current-DAC magnitude code
- ATTEN_W, 10, VGA attenuation code width (larger = more attenuation)
- ATTEN_INIT, 512, attenuation code after reset
- ACC_LOG2, 5, estimation window = 2^ACC_LOG2 valid samples
- SETTLE_CYCLES, 8, clock cycles waited after each update before accumulating
- DC_TOL, 1, dead band on window mean, in LSBs
- LOCK_COUNT, 4, consecutive no-change updates required for lock
- clock  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- enable  in  1  run loops; low aborts to IDLE
- adc_valid  in  1  adc_data valid this cycle
- adc_data  in  NUM_CH*ADC_W  channel k at bits [k*ADC_W +: ADC_W]
- agc_target  in  ADC_W  target peak magnitude
- agc_hyst  in  ADC_W  AGC dead band half-width
- current_dac_0  out  NUM_CH*DAC_W  positive-offset correction magnitude
- current_dac_1  out  NUM_CH*DAC_W  negative-offset correction magnitude
- vga_atten  out  NUM_CH*ATTEN_W  attenuation code per channel
- update_pulse  out  1  one-cycle strobe in UPDATE
- busy  out  1  state != IDLE
- locked  out  1  loops converged

## Operation
- FSM: IDLE, SETTLE, ACCUM, UPDATE.
- IDLE: enable=1 moves to SETTLE and clears the settle counter.
- SETTLE: counts SETTLE_CYCLES clocks, then moves to ACCUM. adc_valid is ignored. Accumulators, peaks and the sample counter are cleared on entry to ACCUM.
- ACCUM: for each cycle with adc_valid=1, per channel:
  - s = adc - 2^(ADC_W-1), signed ADC_W+1.
  - sum += s; sum is signed ADC_W+ACC_LOG2+1 and cannot overflow.
  - peak = max(peak, |s|).
- The sample counter counts valid cycles only. After 2^ACC_LOG2 samples, go to UPDATE.
- UPDATE (exactly one cycle, adc_valid ignored), per channel:
  - mean = sum >>> ACC_LOG2 (arithmetic shift).
  - DC loop: offset code oc is signed DAC_W+1. If mean > DC_TOL, oc += 1. If mean < -DC_TOL, oc -= 1. Otherwise hold. oc saturates at ±(2^DAC_W-1).
  - Output mapping: current_dac_0 = oc>0 ? oc : 0; current_dac_1 = oc<0 ? -oc : 0. Both are never nonzero together.
  - AGC loop: if peak > target+hyst, atten += 1. If peak < target-hyst, atten -= 1. Otherwise hold. atten saturates at 0 and 2^ATTEN_W-1. Threshold comparisons use ADC_W+1-bit unsigned arithmetic; target-hyst below 0 clamps to 0.
  - A saturated code that cannot move counts as no change.
- After UPDATE: go to SETTLE if enable, else IDLE.
- Lock counter:
  - Increments on an UPDATE in which no channel changed oc or atten; saturates at LOCK_COUNT.
  - locked = (count == LOCK_COUNT).
  - Any change, or enable=0, clears the counter and locked.
- enable=0 in any non-IDLE state: go to IDLE next cycle. The partial window is discarded and codes hold. No update_pulse unless already in UPDATE.
- reset: state IDLE, oc=0, atten=ATTEN_INIT, counters 0.
- Reset values of outputs: current_dac_0/1=0, vga_atten=ATTEN_INIT, update_pulse=0, busy=0, locked=0.

## Timing
- All outputs are registered.
- New codes appear on the edge ending UPDATE, i.e. the cycle after update_pulse.
- With adc_valid held at 1 and enable sampled high at edge 0:
  - SETTLE covers cycles 1..8.
  - ACCUM covers cycles 9..40.
  - update_pulse is high in cycle 41; codes change at cycle 42.
- Steady-state update period: 1 + SETTLE_CYCLES + 2^ACC_LOG2 cycles, plus any adc_valid gaps.
- adc_valid gaps stretch ACCUM without bound; there is no timeout.
- reset has priority over enable in the same cycle.

## Test plan
- Reset: assert reset 2 cycles with enable=1 → dac outputs 0, vga_atten=512 both channels, busy=0, locked=0, no update_pulse.
- DC positive: ch0 adc=140, ch1 adc=128, target=100, hyst=8, adc_valid=1 → update_pulse at cycle 41. From cycle 42: ch0 dac_0=1, dac_1=0; ch1 dacs 0; both atten=511.
- DC saturation/negative: ch0 adc=255 for 70 updates → dac_0 saturates at 63, atten reaches 582. Then adc=0 → dac_0 steps 63→0 over 63 updates, then dac_1 rises 1,2,…
- Lock: both channels alternate 228/28 (mean 0, peak 100), target=100, hyst=8 → no code changes; locked=1 after the 4th update_pulse. A step of ch1 to 140 clears locked at the next update.
- Abort: drop enable during ACCUM sample 20, re-raise 3 cycles later → no update_pulse, codes unchanged. The next update_pulse arrives 1+8+32 cycles after re-enable, using only fresh samples.
- Valid gaps: adc_valid toggling every other cycle → UPDATE after exactly 32 valid samples (about 64 cycles of ACCUM); results identical to the gap-free run.
